// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared encodings, opcodes and the default TFT init script
package tft_pkg;

   // Script opcode in the two top bits of every entry
   typedef enum logic [1:0] {
      COMM = 2'b00,
      DATA = 2'b01,
      WAIT = 2'b10,
      END  = 2'b11
   } op_t;

   typedef struct packed {
      op_t        op;
      logic [7:0] payload;
   } entry_t;

   localparam int ENTRY_W   = 10;
   localparam int MAX_DEPTH = 64;

   localparam logic [7:0] CASET = 8'h2A;
   localparam logic [7:0] PASET = 8'h2B;
   localparam logic [7:0] RAMWR = 8'h2C;

   function automatic logic [ENTRY_W-1:0] ent(input op_t op, input logic [7:0] b);
      return {op, b};
   endfunction

   // Panel bring-up: each command followed by its parameter bytes, sleep-out wait, display on
   localparam int INIT_LEN = 33;
   localparam logic [ENTRY_W-1:0] INIT_LIST [INIT_LEN] = '{
      ent(COMM, 8'hC0), ent(DATA, 8'h17), ent(DATA, 8'h15),
      ent(COMM, 8'hC1), ent(DATA, 8'h41),
      ent(COMM, 8'hC5), ent(DATA, 8'h00), ent(DATA, 8'h12), ent(DATA, 8'h80),
      ent(COMM, 8'h36), ent(DATA, 8'h48),
      ent(COMM, 8'h3A), ent(DATA, 8'h66),
      ent(COMM, 8'hB0), ent(DATA, 8'h00),
      ent(COMM, 8'hB1), ent(DATA, 8'hA0),
      ent(COMM, 8'hB6), ent(DATA, 8'h02), ent(DATA, 8'h02),
      ent(COMM, 8'hE9), ent(DATA, 8'h00),
      ent(COMM, 8'hF7), ent(DATA, 8'hA9), ent(DATA, 8'h51), ent(DATA, 8'h2C), ent(DATA, 8'h82),
      ent(COMM, 8'h11),
      ent(WAIT, 8'hFF),
      ent(COMM, 8'h29), ent(COMM, 8'h21), ent(COMM, 8'h34),
      ent(END,  8'h00)
   };

   // Flattened ROM image, entry 0 in the low bits; unused slots hold END
   function automatic logic [MAX_DEPTH*ENTRY_W-1:0] pack_script();
      logic [MAX_DEPTH*ENTRY_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_DEPTH; i++) r[i*ENTRY_W +: ENTRY_W] = ent(END, 8'h00);
      for (int i = 0; i < INIT_LEN; i++) r[i*ENTRY_W +: ENTRY_W] = INIT_LIST[i];
      return r;
   endfunction

   localparam logic [MAX_DEPTH*ENTRY_W-1:0] INIT_SCRIPT = pack_script();

endpackage

// File: rtl/tft_ms_timer.sv
// rtl/tft_ms_timer.sv - millisecond prescaler and down-counter for script waits
module tft_ms_timer #(
   parameter int CLK_HZ = 50_000_000,
   parameter int WAIT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WAIT_W-1:0] i_ms,
   output logic              o_expired
);
   localparam int PRESC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
   localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

   logic [PW-1:0]     r_pre;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_zero;
   logic              w_tick;

   assign w_tick    = (r_pre == PW'(PRESC - 1));
   // Fires in the cycle the last millisecond completes, or right after a zero load
   assign o_expired = r_zero | ((r_cnt == WAIT_W'(1)) & w_tick);

   // Prescaler restarts on every load so the first millisecond is a full one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre  <= '0;
         r_cnt  <= '0;
         r_zero <= 1'b0;
      end else if (i_load) begin
         r_pre  <= '0;
         r_cnt  <= i_ms;
         r_zero <= (i_ms == '0);
      end else begin
         r_zero <= 1'b0;
         if (r_cnt != '0) begin
            if (w_tick) begin
               r_pre <= '0;
               r_cnt <= r_cnt - 1'b1;
            end else begin
               r_pre <= r_pre + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/tft_cmd_seq.sv
// rtl/tft_cmd_seq.sv - init script player and window-select sequencer for the TFT byte transmitter
module tft_cmd_seq import tft_pkg::*; #(
   parameter int DEPTH   = 64,
   parameter int CLK_HZ  = 50_000_000,
   parameter int WAIT_W  = 8,
   parameter int COORD_W = 16,
   parameter logic [MAX_DEPTH*ENTRY_W-1:0] SCRIPT = INIT_SCRIPT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start_init,
   input  logic               i_start_window,
   input  logic [COORD_W-1:0] i_x0,
   input  logic [COORD_W-1:0] i_x1,
   input  logic [COORD_W-1:0] i_y0,
   input  logic [COORD_W-1:0] i_y1,
   input  logic               i_tft_busy,
   output logic               o_tft_dc,
   output logic [7:0]         o_tft_data,
   output logic               o_tft_transmit,
   output logic               o_busy,
   output logic               o_done
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WIN, SEND, DELAY, FIN} state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       r_step;
   logic             r_win;
   logic [15:0]      r_x0, r_x1, r_y0, r_y1;
   logic             r_pend_dc;
   logic [7:0]       r_pend_data;
   logic             r_guard;
   logic             r_dc, r_tx, r_busy, r_done;
   logic [7:0]       r_data;

   entry_t           w_entry;
   logic             w_load, w_expired;
   logic             w_win_dc;
   logic [7:0]       w_win_byte;

   assign w_entry = entry_t'(SCRIPT[int'(r_idx)*ENTRY_W +: ENTRY_W]);
   assign w_load  = (r_state == FETCH) && (w_entry.op == WAIT);

   assign o_tft_dc       = r_dc;
   assign o_tft_data     = r_data;
   assign o_tft_transmit = r_tx;
   assign o_busy         = r_busy;
   assign o_done         = r_done;

   tft_ms_timer #(.CLK_HZ(CLK_HZ), .WAIT_W(WAIT_W)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_ms      (WAIT_W'(w_entry.payload)),
      .o_expired (w_expired)
   );

   // Byte for the current window step: three opcodes framing big-endian coordinate pairs
   always_comb begin
      w_win_dc   = 1'b1;
      w_win_byte = 8'h00;
      case (r_step)
         4'd0:    begin w_win_dc = 1'b0; w_win_byte = CASET; end
         4'd1:    w_win_byte = r_x0[15:8];
         4'd2:    w_win_byte = r_x0[7:0];
         4'd3:    w_win_byte = r_x1[15:8];
         4'd4:    w_win_byte = r_x1[7:0];
         4'd5:    begin w_win_dc = 1'b0; w_win_byte = PASET; end
         4'd6:    w_win_byte = r_y0[15:8];
         4'd7:    w_win_byte = r_y0[7:0];
         4'd8:    w_win_byte = r_y1[15:8];
         4'd9:    w_win_byte = r_y1[7:0];
         default: begin w_win_dc = 1'b0; w_win_byte = RAMWR; end
      endcase
   end

   // Sequencer FSM; strobe, done and busy are all registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_step      <= '0;
         r_win       <= 1'b0;
         r_x0        <= '0;
         r_x1        <= '0;
         r_y0        <= '0;
         r_y1        <= '0;
         r_pend_dc   <= 1'b0;
         r_pend_data <= '0;
         r_guard     <= 1'b0;
         r_dc        <= 1'b0;
         r_data      <= '0;
         r_tx        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_tx    <= 1'b0;
         r_done  <= 1'b0;
         r_guard <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start_init) begin
                  r_idx   <= '0;
                  r_win   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= FETCH;
               end else if (i_start_window) begin
                  r_x0    <= 16'(i_x0);
                  r_x1    <= 16'(i_x1);
                  r_y0    <= 16'(i_y0);
                  r_y1    <= 16'(i_y1);
                  r_step  <= '0;
                  r_win   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= WIN;
               end
            end
            FETCH: begin
               case (w_entry.op)
                  COMM, DATA: begin
                     r_pend_dc   <= (w_entry.op == DATA);
                     r_pend_data <= w_entry.payload;
                     r_state     <= SEND;
                  end
                  WAIT:    r_state <= DELAY;
                  default: r_state <= FIN;
               endcase
            end
            WIN: begin
               r_pend_dc   <= w_win_dc;
               r_pend_data <= w_win_byte;
               r_state     <= SEND;
            end
            SEND: begin
               if (!i_tft_busy && !r_guard) begin
                  r_tx    <= 1'b1;
                  r_guard <= 1'b1;
                  r_dc    <= r_pend_dc;
                  r_data  <= r_pend_data;
                  if (r_win) begin
                     if (r_step == 4'd10) r_state <= FIN;
                     else begin
                        r_step  <= r_step + 1'b1;
                        r_state <= WIN;
                     end
                  end else if (r_idx == LAST_IDX) begin
                     r_state <= FIN;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= FETCH;
                  end
               end
            end
            DELAY: begin
               if (w_expired) begin
                  if (r_idx == LAST_IDX) r_state <= FIN;
                  else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= FETCH;
                  end
               end
            end
            default: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tft_cmd_seq.sv
// tb/tb_tft_cmd_seq.sv - directed self-checking bench for tft_cmd_seq
module tb_tft_cmd_seq;
   import tft_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start_init, start_window, tft_busy;
   logic [15:0] x0, x1, y0, y1;
   logic        dc, tx, busy, done;
   logic [7:0]  data;

   logic        start2, busy2;
   logic        dc2, tx2, bsy2, done2;
   logic [7:0]  data2;

   localparam logic [MAX_DEPTH*ENTRY_W-1:0] SHORT_SCRIPT =
      {{((MAX_DEPTH-5)*ENTRY_W){1'b0}}, 10'h1EE, 10'h1DD, 10'h1CC, 10'h1BB, 10'h1AA};

   tft_cmd_seq #(.CLK_HZ(1000)) dut (
      .clk(clk), .rst(rst), .i_start_init(start_init), .i_start_window(start_window),
      .i_x0(x0), .i_x1(x1), .i_y0(y0), .i_y1(y1), .i_tft_busy(tft_busy),
      .o_tft_dc(dc), .o_tft_data(data), .o_tft_transmit(tx), .o_busy(busy), .o_done(done)
   );

   tft_cmd_seq #(.DEPTH(4), .CLK_HZ(1000), .SCRIPT(SHORT_SCRIPT)) dut4 (
      .clk(clk), .rst(rst), .i_start_init(start2), .i_start_window(1'b0),
      .i_x0(x0), .i_x1(x1), .i_y0(y0), .i_y1(y1), .i_tft_busy(busy2),
      .o_tft_dc(dc2), .o_tft_data(data2), .o_tft_transmit(tx2), .o_busy(bsy2), .o_done(done2)
   );

   logic [8:0] INIT_EXP [31] = '{
      9'h0C0, 9'h117, 9'h115, 9'h0C1, 9'h141, 9'h0C5, 9'h100, 9'h112, 9'h180,
      9'h036, 9'h148, 9'h03A, 9'h166, 9'h0B0, 9'h100, 9'h0B1, 9'h1A0, 9'h0B6,
      9'h102, 9'h102, 9'h0E9, 9'h100, 9'h0F7, 9'h1A9, 9'h151, 9'h12C, 9'h182,
      9'h011, 9'h029, 9'h021, 9'h034};
   logic [8:0] WIN_EXP [11] = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02B,
                                9'h100, 9'h100, 9'h101, 9'h1DF, 9'h02C};
   logic [8:0] BP_EXP  [11] = '{9'h02A, 9'h112, 9'h134, 9'h100, 9'h156, 9'h02B,
                                9'h1AB, 9'h1CD, 9'h100, 9'h101, 9'h02C};
   logic [8:0] SHORT_EXP [4] = '{9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD};

   int n_vec = 0, n_err = 0, cyc = 0;
   logic [8:0] sq[$], sq2[$];
   int scyc[$], scyc2[$];
   int n_done, done_cyc, n_done2, done2_cyc;
   logic done_busy;
   int busy_viol, stab_viol, bp_cnt, c0;
   logic bp_en, have_last;
   logic [8:0] last_byte;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (tx) begin
         sq.push_back({dc, data});
         scyc.push_back(cyc);
         if (tft_busy) busy_viol++;
         last_byte = {dc, data};
         have_last = 1'b1;
      end else if (bp_en && have_last && ({dc, data} !== last_byte)) begin
         stab_viol++;
      end
      if (done) begin
         n_done++;
         done_cyc  = cyc;
         done_busy = busy;
      end
      if (tx2) begin
         sq2.push_back({dc2, data2});
         scyc2.push_back(cyc);
      end
      if (done2) begin
         n_done2++;
         done2_cyc = cyc;
      end
      if (bp_en) begin
         tft_busy = (bp_cnt > 0);
         if (tx) bp_cnt = 10;
         else if (bp_cnt > 0) bp_cnt--;
      end
   endtask

   task automatic clear_log();
      sq.delete(); scyc.delete(); sq2.delete(); scyc2.delete();
      n_done = 0; n_done2 = 0; busy_viol = 0; stab_viol = 0; have_last = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int k = 0; k < budget && n_done == 0; k++) tick();
      check(tag, 32'(n_done > 0), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_dc"},   32'(dc),   32'd0);
      check({tag, "_data"}, 32'(data), 32'd0);
      check({tag, "_tx"},   32'(tx),   32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start_init = 1'b0; start_window = 1'b0; tft_busy = 1'b0;
      start2 = 1'b0; busy2 = 1'b0; bp_en = 1'b0; bp_cnt = 0;
      x0 = '0; x1 = '0; y0 = '0; y1 = '0;
      clear_log();
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      repeat (2) tick();

      // Window, never-busy transmitter; coordinate changes after start must not matter
      clear_log();
      x0 = 16'd0; x1 = 16'd319; y0 = 16'd0; y1 = 16'd479;
      start_window = 1'b1;
      tick();
      start_window = 1'b0;
      c0 = cyc;
      check("win_busy_rise", 32'(busy), 32'd1);
      x0 = 16'hFFFF; x1 = 16'hEEEE; y0 = 16'hDDDD; y1 = 16'hCCCC;
      wait_done("win_completes", 200);
      repeat (5) tick();
      check("win_count", sq.size(), 32'd11);
      for (int i = 0; i < 11; i++) check($sformatf("win_byte%0d", i), 32'(sq[i]), 32'(WIN_EXP[i]));
      check("win_first_latency", scyc[0] - c0, 32'd2);
      check("win_spacing", scyc[10] - scyc[0], 32'd20);
      check("win_done_cycle", done_cyc - scyc[10], 32'd1);
      check("win_done_busy", 32'(done_busy), 32'd0);
      check("win_done_once", n_done, 32'd1);

      // Init with simultaneous window request, plus a window pulse while busy
      clear_log();
      x0 = 16'd5; x1 = 16'd6; y0 = 16'd7; y1 = 16'd8;
      start_init = 1'b1; start_window = 1'b1;
      tick();
      start_init = 1'b0; start_window = 1'b0;
      c0 = cyc;
      repeat (5) tick();
      start_window = 1'b1;
      tick();
      start_window = 1'b0;
      wait_done("init_completes", 1000);
      repeat (30) tick();
      check("init_count", sq.size(), 32'd31);
      for (int i = 0; i < 31; i++) check($sformatf("init_byte%0d", i), 32'(sq[i]), 32'(INIT_EXP[i]));
      check("init_first_latency", scyc[0] - c0, 32'd2);
      check("init_wait_gap", 32'((scyc[28] - scyc[27]) >= 256 && (scyc[28] - scyc[27]) <= 258), 32'd1);
      check("init_done_cycle", done_cyc - scyc[30], 32'd2);
      check("init_done_busy", 32'(done_busy), 32'd0);
      check("init_done_once", n_done, 32'd1);

      // Backpressure: busy for 10 cycles after each strobe, reversed coordinates pass through
      clear_log();
      bp_en = 1'b1; bp_cnt = 0;
      x0 = 16'h1234; x1 = 16'h0056; y0 = 16'hABCD; y1 = 16'h0001;
      start_window = 1'b1;
      tick();
      start_window = 1'b0;
      wait_done("bp_completes", 400);
      bp_en = 1'b0; tft_busy = 1'b0;
      check("bp_count", sq.size(), 32'd11);
      for (int i = 0; i < 11; i++) check($sformatf("bp_byte%0d", i), 32'(sq[i]), 32'(BP_EXP[i]));
      check("bp_strobe_while_busy", busy_viol, 32'd0);
      check("bp_data_held", stab_viol, 32'd0);
      check("bp_spacing", scyc[1] - scyc[0], 32'd12);

      // Reset in the middle of the long wait
      clear_log();
      start_init = 1'b1;
      tick();
      start_init = 1'b0;
      for (int k = 0; k < 200 && sq.size() < 28; k++) tick();
      check("rst_reached_wait", sq.size(), 32'd28);
      repeat (50) tick();
      rst = 1'b1;
      tick();
      check_idle_outputs("rst_mid");
      rst = 1'b0;
      clear_log();
      repeat (400) tick();
      check("rst_no_strobe", sq.size(), 32'd0);
      check("rst_no_done", n_done, 32'd0);

      // Four-entry script with no END: stops after the last index
      clear_log();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (40) tick();
      check("short_count", sq2.size(), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("short_byte%0d", i), 32'(sq2[i]), 32'(SHORT_EXP[i]));
      check("short_done_once", n_done2, 32'd1);
      check("short_done_cycle", done2_cyc - scyc2[3], 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
